// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the board SPI port: grants one requester at a time,
// keeps chip-select for that owner until it releases, and shifts bytes in mode 0.
module spi_bus_arbiter #(
    parameter int NumReq = 2,
    parameter int ClkDiv = 4
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_sys_ni,
    input  logic [NumReq-1:0]     req_i,
    output logic [NumReq-1:0]     gnt_o,
    input  logic [NumReq-1:0]     tx_valid_i,
    input  logic [8*NumReq-1:0]   tx_data_i,
    output logic [NumReq-1:0]     tx_ready_o,
    output logic [NumReq-1:0]     rx_valid_o,
    output logic [7:0]            rx_data_o,
    output logic                  busy_o,
    input  logic                  spi_rx_i,
    output logic                  spi_tx_o,
    output logic                  spi_sck_o,
    output logic                  spi_cs_no
);

    localparam int PtrW = $clog2(NumReq);
    localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv + 1) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);
    localparam logic [PtrW-1:0] LastReq = PtrW'(NumReq - 1);

    if (ClkDiv < 1) begin : g_bad_clkdiv
        $error("spi_bus_arbiter: ClkDiv must be at least 1");
    end
    if (NumReq < 2) begin : g_bad_numreq
        $error("spi_bus_arbiter: NumReq must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, OWN, SHIFT, HOLD} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   owner_q, owner_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [NumReq-1:0] gnt_q, gnt_d;
    logic [NumReq-1:0] rx_valid_q, rx_valid_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_bit_q, rx_bit_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DivW-1:0]   div_cnt_q, div_cnt_d;
    logic              sck_q, sck_d;
    logic              cs_n_q, cs_n_d;

    logic              win_found, hi_found;
    logic [PtrW-1:0]   win_idx, hi_idx, win_next;
    logic              sel_req, sel_valid;
    logic [7:0]        sel_byte;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        hi_found  = 1'b0;
        hi_idx    = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                win_found = 1'b1;
                win_idx   = PtrW'(i);
                if (i >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = PtrW'(i);
                end
            end
        end
        if (hi_found) begin
            win_idx = hi_idx;
        end
        win_next = (win_idx == LastReq) ? '0 : win_idx + 1'b1;
    end

    always_comb begin
        sel_req   = 1'b0;
        sel_valid = 1'b0;
        sel_byte  = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (owner_q == PtrW'(i)) begin
                sel_req   = req_i[i];
                sel_valid = tx_valid_i[i];
                sel_byte  = tx_data_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        rx_valid_d = '0;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_bit_d   = rx_bit_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        sck_d      = sck_q;
        cs_n_d     = cs_n_q;
        unique case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sck_d  = 1'b0;
                if (win_found) begin
                    state_d = OWN;
                    owner_d = win_idx;
                    gnt_d   = {{(NumReq-1){1'b0}}, 1'b1} << win_idx;
                    ptr_d   = win_next;
                    cs_n_d  = 1'b0;
                end
            end
            OWN: begin
                if (sel_valid) begin
                    state_d   = SHIFT;
                    shift_d   = sel_byte;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    sck_d     = 1'b0;
                end else if (!sel_req) begin
                    state_d   = HOLD;
                    gnt_d     = '0;
                    div_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (div_cnt_q == DivLast) begin
                    div_cnt_d = '0;
                    if (!sck_q) begin
                        sck_d    = 1'b1;
                        rx_bit_d = spi_rx_i;
                    end else begin
                        // Falling edge: advance MOSI and pull in the bit sampled on the rise.
                        sck_d     = 1'b0;
                        shift_d   = {shift_q[6:0], rx_bit_q};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d    = OWN;
                            rx_valid_d = gnt_q;
                            rx_data_d  = {shift_q[6:0], rx_bit_q};
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_cnt_q == DivLast) begin
                    state_d   = IDLE;
                    cs_n_d    = 1'b1;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            gnt_q      <= '0;
            rx_valid_q <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_bit_q   <= 1'b0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            rx_valid_q <= rx_valid_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_bit_q   <= rx_bit_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign tx_ready_o = (state_q == OWN) ? gnt_q : '0;
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign busy_o     = (state_q != IDLE);
    assign spi_tx_o   = (state_q == SHIFT) && shift_q[7];
    assign spi_sck_o  = sck_q;
    assign spi_cs_no  = cs_n_q;

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
Shares the single board SPI port (SPI_TX/SPI_RX/SPI_SCK plus chip-select) between NumReq on-chip requesters, for example the core's SPI host and a flash boot loader.
- Arbitration is round-robin at transaction granularity. A granted requester owns the bus and chip-select until it drops its request.
- Contains the mode-0 byte shift engine and the SCK divider.
- Sits between the SoC peripherals and the FPGA top-level pins, in the clk_sys domain.

Parameters:
NumReq, 2, number of requesters (>=2).
ClkDiv, 4, SCK half-period in clk_sys cycles (>=1; 0 is illegal and flagged by an elaboration assertion).

Ports:
clk_sys_i  in  1  system clock; the only clock.
rst_sys_ni  in  1  asynchronous active-low reset.
req_i  in  NumReq  bus request per requester; held high for the whole transaction.
gnt_o  out  NumReq  one-hot grant (all zero when no owner).
tx_valid_i  in  NumReq  byte-to-send valid per requester.
tx_data_i  in  8*NumReq  packed bytes; requester k uses bits [8k+7:8k].
tx_ready_o  out  NumReq  byte accepted; only the owner's bit can be high.
rx_valid_o  out  NumReq  one-cycle pulse to the owner: received byte available.
rx_data_o  out  8  received byte; shared, qualified by rx_valid_o.
busy_o  out  1  high in every state except IDLE.
spi_rx_i  in  1  MISO.
spi_tx_o  out  1  MOSI.
spi_sck_o  out  1  SCK, idle low (mode 0).
spi_cs_no  out  1  chip-select, active low.

Behaviour:
Reset (asynchronous, takes effect immediately, including mid-byte):
- spi_cs_no=1; every other output 0.
- Round-robin pointer = 0.
- No rx_valid_o pulse is issued for an aborted byte.

State machine: IDLE, OWN, SHIFT, HOLD.

IDLE:
- gnt_o=0, spi_cs_no=1, spi_sck_o=0, spi_tx_o=0.
- If any req_i bit is high, the winner is the first requester at or after the pointer (wrapping at NumReq).
- Next cycle: state=OWN, gnt_o[winner]=1, spi_cs_no=0, pointer=(winner+1) mod NumReq.

OWN:
- tx_ready_o[owner]=1.
- Handshake (tx_valid_i[owner] & tx_ready_o[owner]): load the byte into the shift register, state=SHIFT.
- Else if req_i[owner]=0: state=HOLD, gnt_o cleared on entry.
- Request drop and handshake in the same cycle: the handshake wins. The byte completes; the drop is seen on the return to OWN.

SHIFT (mode 0, MSB first):
- spi_tx_o=shift[7] from the first SHIFT cycle. tx_ready_o=0.
- Each bit: ClkDiv cycles SCK low, then ClkDiv cycles SCK high.
- spi_rx_i is sampled in the cycle SCK rises. The shift register moves on the falling edge.
- 8 bits take 16*ClkDiv cycles.
- rx_valid_o[owner] pulses exactly 16*ClkDiv+1 cycles after the handshake cycle, with rx_data_o = the assembled byte. State returns to OWN in that same cycle.
- spi_cs_no stays 0 between back-to-back bytes.

HOLD:
- spi_cs_no stays 0 for ClkDiv cycles (CS hold), then state=IDLE and spi_cs_no=1.
- IDLE lasts at least 1 cycle, so CS is high for at least 1 cycle between owners.

Other rules:
- req_i of non-owners is ignored outside IDLE. tx_valid_i of non-owners is ignored.
- rx_data_o holds its last value between pulses.
- The bit counter is 3 bits. The divider counter width is $clog2(ClkDiv+1) and it wraps to 0 at ClkDiv-1.
- A requester that raises and drops req_i while not granted gets no grant.

Test Plan:
- Single byte, ClkDiv=2: req_i=01, send 0xA5 with spi_rx_i looped to spi_tx_o -> gnt_o=01 one cycle later; 8 SCK pulses of 2-high/2-low; MOSI=1,0,1,0,0,1,0,1; rx_valid_o=01 with rx_data_o=0xA5 at handshake+33; CS high 2 cycles after req drop.
- Contention: req_i=11 from reset -> owner 0 first; after its release, owner 1; then, with 0 requesting again, owner 0 (strict alternation); gnt_o never has 2 bits set.
- Back-to-back: owner sends 0x12, 0x34, 0x56 with tx_valid_i held -> spi_cs_no stays 0 across all 24 bits; three rx_valid_o pulses spaced 16*ClkDiv+1 cycles apart.
- Release with simultaneous handshake: req drop and tx_valid_i in the same OWN cycle -> byte fully shifted, rx_valid_o pulses, then HOLD then IDLE.
- Async reset at bit 4 of a byte -> spi_cs_no=1, spi_sck_o=0, gnt_o=0 immediately; no rx_valid_o; after release, requester 0 wins first.
- Non-owner isolation: owner 0 shifting while requester 1 pulses tx_valid_i with 0xFF -> tx_ready_o[1]=0 throughout and MOSI carries owner 0's data only.
